vector_alu_sequencer: RTL and testbench

//  Sequences the shared 8-bit vector ALU (R,S,ALU_Op -> Y, combinational) over a
//  4-lane packed 32-bit vector op, one lane per clock. Adds a lane-wise 8x8

---
 rtl/vec_alu_pkg.sv | 26 ++
 rtl/vec_lane_mux.sv | 40 ++++
 rtl/vector_alu_sequencer.sv | 159 +++++++++++++++
 tb/tb_vector_alu_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Package: vec_alu_pkg
// Purpose: Shared constants and state encoding for the vector ALU sequencer.
//   LANES   lanes per packed vector (lane k = bits [8k+7:8k])
//   W       lane and ALU data width
//   OP_W    ALU opcode width
//   OP_ADD  ALU add opcode, also used for every multiply step
//   OP_MUL  sequencer-only multiply opcode, never sent to the ALU
package vec_alu_pkg;

    localparam int LANES  = 4;
    localparam int W      = 8;
    localparam int OP_W   = 5;
    localparam int LANE_W = $clog2(LANES);
    localparam int BIT_W  = $clog2(W);

    localparam logic [OP_W-1:0] OP_ADD = 5'b01010;
    localparam logic [OP_W-1:0] OP_MUL = 5'b01100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/vec_lane_mux.sv
// Module: vec_lane_mux
// Purpose: Lane selection for the vector ALU sequencer. Extracts the W-bit
//   lane of the latched R/S operands chosen by lane_sel, and builds the
//   result vector with that lane replaced by wr_data.
// Ports:
//   vec_r, vec_s  in   latched operand vectors
//   vec_y         in   current result vector
//   lane_sel      in   active lane index
//   wr_data       in   value to place into the active lane of the result
//   r_lane,s_lane out  active lane of R and S
//   y_next        out  vec_y with the active lane replaced (caller gates the write)
module vec_lane_mux
    import vec_alu_pkg::*;
(
    input  logic [LANES*W-1:0] vec_r,
    input  logic [LANES*W-1:0] vec_s,
    input  logic [LANES*W-1:0] vec_y,
    input  logic [LANE_W-1:0]  lane_sel,
    input  logic [W-1:0]       wr_data,
    output logic [W-1:0]       r_lane,
    output logic [W-1:0]       s_lane,
    output logic [LANES*W-1:0] y_next
);

    // Decode the lane index once and use it both for the operand read
    // and for the result write-back slot.
    always_comb begin
        r_lane = '0;
        s_lane = '0;
        y_next = vec_y;
        for (int k = 0; k < LANES; k++) begin
            if (lane_sel == LANE_W'(k)) begin
                r_lane             = vec_r[k*W +: W];
                s_lane             = vec_s[k*W +: W];
                y_next[k*W +: W]   = wr_data;
            end
        end
    end

endmodule

// File: rtl/vector_alu_sequencer.sv
// Module: vector_alu_sequencer
// Purpose: Drives one shared combinational 8-bit ALU over a 4-lane packed
//   vector, one lane per clock. OP_MUL is handled here as a lane-wise 8x8
//   multiply (low W bits) made of W shift-add steps through the ALU's add.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request, taken only in IDLE or DONE
//   op_in, vec_r/s    operation and operand vectors, latched at accept
//   busy              high while lanes are being processed
//   done              one-cycle pulse, vec_y valid
//   vec_y             result vector, held from done until the next accept
//   alu_r/alu_s/alu_op  drive to the external ALU
//   alu_y             combinational ALU result
module vector_alu_sequencer
    import vec_alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [OP_W-1:0]    op_in,
    input  logic [LANES*W-1:0] vec_r,
    input  logic [LANES*W-1:0] vec_s,
    output logic               busy,
    output logic               done,
    output logic [LANES*W-1:0] vec_y,
    output logic [W-1:0]       alu_r,
    output logic [W-1:0]       alu_s,
    output logic [OP_W-1:0]    alu_op,
    input  logic [W-1:0]       alu_y
);

    seq_state_t         state;
    seq_state_t         next_state;
    logic [OP_W-1:0]    op_q;
    logic [LANES*W-1:0] r_q;
    logic [LANES*W-1:0] s_q;
    logic [LANE_W-1:0]  lane_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [W-1:0]       acc;
    logic [W-1:0]       r_lane;
    logic [W-1:0]       s_lane;
    logic [W-1:0]       r_shifted;
    logic [LANES*W-1:0] y_next;
    logic               accept;
    logic               y_wr_en;
    logic               lane_last;
    logic               bit_last;

    assign lane_last = (lane_cnt == LANE_W'(LANES - 1));
    assign bit_last  = (bit_cnt == BIT_W'(W - 1));
    assign r_shifted = r_lane << bit_cnt;

    vec_lane_mux u_lane_mux (
        .vec_r    (r_q),
        .vec_s    (s_q),
        .vec_y    (vec_y),
        .lane_sel (lane_cnt),
        .wr_data  (alu_y),
        .r_lane   (r_lane),
        .s_lane   (s_lane),
        .y_next   (y_next)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and ALU drive. In MUL the ALU only ever adds:
    // acc + (R shifted by the current bit if that bit of S is set).
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        alu_r      = '0;
        alu_s      = '0;
        alu_op     = '0;
        y_wr_en    = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done       = (state == ST_DONE);
                next_state = ST_IDLE;
                if (start) begin
                    accept     = 1'b1;
                    next_state = (op_in == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy    = 1'b1;
                alu_r   = r_lane;
                alu_s   = s_lane;
                alu_op  = op_q;
                y_wr_en = 1'b1;
                if (lane_last) begin
                    next_state = ST_DONE;
                end
            end
            ST_MUL: begin
                busy   = 1'b1;
                alu_op = OP_ADD;
                alu_r  = acc;
                alu_s  = s_lane[bit_cnt] ? r_shifted : '0;
                if (bit_last) begin
                    y_wr_en = 1'b1;
                    if (lane_last) begin
                        next_state = ST_DONE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Operand latches, lane/bit counters, multiply accumulator and result.
    // acc is zeroed on accept and at every lane boundary so each lane's
    // first multiply step starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            r_q      <= '0;
            s_q      <= '0;
            lane_cnt <= '0;
            bit_cnt  <= '0;
            acc      <= '0;
            vec_y    <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_in;
                r_q      <= vec_r;
                s_q      <= vec_s;
                lane_cnt <= '0;
                bit_cnt  <= '0;
                acc      <= '0;
            end else if (state == ST_EXEC) begin
                lane_cnt <= lane_cnt + LANE_W'(1);
            end else if (state == ST_MUL) begin
                if (bit_last) begin
                    bit_cnt  <= '0;
                    acc      <= '0;
                    lane_cnt <= lane_cnt + LANE_W'(1);
                end else begin
                    bit_cnt  <= bit_cnt + BIT_W'(1);
                    acc      <= alu_y;
                end
            end
            if (y_wr_en) begin
                vec_y <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Testbench: tb_vector_alu_sequencer
// Purpose: Drives vector_alu_sequencer against a behavioural ALU (add, else
//   pass S) and checks results, start-to-done latency, busy length and the
//   multiply ALU opcode through a scoreboard fed at accept time.
module tb_vector_alu_sequencer;
    import vec_alu_pkg::*;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  op;
        int          accept_cycle;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  op_in;
    logic [31:0] vec_r;
    logic [31:0] vec_s;
    logic        busy;
    logic        done;
    logic [31:0] vec_y;
    logic [7:0]  alu_r;
    logic [7:0]  alu_s;
    logic [4:0]  alu_op;
    logic [7:0]  alu_y;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    int   busy_cnt = 0;

    vector_alu_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_in  (op_in),
        .vec_r  (vec_r),
        .vec_s  (vec_s),
        .busy   (busy),
        .done   (done),
        .vec_y  (vec_y),
        .alu_r  (alu_r),
        .alu_s  (alu_s),
        .alu_op (alu_op),
        .alu_y  (alu_y)
    );

    // Stand-in for the shared ALU: add for OP_ADD, anything else passes S.
    always_comb begin
        if (alu_op == OP_ADD) alu_y = alu_r + alu_s;
        else                  alu_y = alu_s;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Lane-wise reference: modulo-256 sum, low byte of the product, or S.
    function automatic logic [31:0] expVec(input logic [4:0] op, input logic [31:0] r,
                                           input logic [31:0] s);
        logic [31:0] y;
        int a, b;
        y = '0;
        for (int k = 0; k < 4; k++) begin
            a = int'(r[8*k +: 8]);
            b = int'(s[8*k +: 8]);
            if (op == OP_ADD)      y[8*k +: 8] = 8'((a + b) % 256);
            else if (op == OP_MUL) y[8*k +: 8] = 8'((a * b) % 256);
            else                   y[8*k +: 8] = 8'(b);
        end
        return y;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request; called at posedge+1, leaves at posedge+1 after accept.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] r,
                                 input logic [31:0] s, input logic [31:0] y);
        exp_t e;
        start = 1'b1;
        op_in = op;
        vec_r = r;
        vec_s = s;
        @(posedge clk);
        #1;
        e.y            = y;
        e.op           = op;
        e.accept_cycle = cycle;
        e.lat          = (op == OP_MUL) ? LANES * W : LANES;
        sb.push_back(e);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL done_timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    // Monitor: counts busy cycles, checks the MUL ALU opcode and compares
    // every done against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                if (sb.size() > 0 && sb[0].op == OP_MUL)
                    checkOutput("mul_alu_op", 32'(alu_op), 32'(OP_ADD));
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no result pending");
                end else begin
                    e = sb.pop_front();
                    checkOutput("vec_y", vec_y, e.y);
                    checkOutput("latency", 32'(cycle - e.accept_cycle), 32'(e.lat));
                    checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.lat));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed cases first, then a randomized mix of ops and operands.
    initial begin
        logic [4:0]  op;
        logic [31:0] r, s;
        rst_n = 1'b0;
        start = 1'b0;
        op_in = '0;
        vec_r = '0;
        vec_s = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_vec_y", vec_y, 32'd0);
        checkOutput("reset_alu_drive", {alu_r, alu_s, 11'(alu_op)}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] add");
        applyStimulus(OP_ADD, 32'h01020304, 32'h10203040, 32'h11223344);
        waitDone(100);

        $display("[TB] add wrap");
        applyStimulus(OP_ADD, 32'hFF807F01, 32'h01800101, 32'h00008002);
        waitDone(100);

        $display("[TB] pass op");
        applyStimulus(5'b00000, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF);
        waitDone(100);

        $display("[TB] mul");
        applyStimulus(OP_MUL, 32'h0310FF07, 32'h05100209, 32'h0F00FE3F);
        waitDone(100);

        $display("[TB] start ignored while busy");
        applyStimulus(OP_ADD, 32'h11111111, 32'h22222222, 32'h33333333);
        @(posedge clk);
        #1;
        start = 1'b1;
        op_in = OP_MUL;
        vec_r = 32'hA5A5A5A5;
        vec_s = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(100);

        $display("[TB] back-to-back accept from DONE");
        applyStimulus(OP_ADD, 32'h0A0B0C0D, 32'h01010101, 32'h0B0C0D0E);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(5'b00111, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF);
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        waitDone(100);

        $display("[TB] reset mid-operation");
        applyStimulus(OP_ADD, 32'h01010101, 32'h02020202, 32'h03030303);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_vec_y", vec_y, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(OP_ADD, 32'h40302010, 32'h04030201, 32'h44332211);
        waitDone(100);

        $display("[TB] random");
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_ADD;
                1:       op = OP_MUL;
                2:       op = 5'b00000;
                default: op = 5'($urandom_range(0, 31));
            endcase
            r = $urandom;
            s = $urandom;
            applyStimulus(op, r, s, expVec(op, r, s));
            waitDone(100);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
